// File: rtl/divide_pkg.sv
// rtl/divide_pkg.sv - shared arithmetic constants and FSM state type
package divide_pkg;

    localparam int DIVIDE_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/divide_if.sv
// rtl/divide_if.sv - start/busy/done request and result bundle for divide
// master: drives start, dividend, divisor; observes busy, done, quotient, remainder, div_by_zero
// slave : the divider side of the same signals
interface divide_if #(
    parameter int WIDTH = divide_pkg::DIVIDE_WIDTH
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divide_div_step.sv
// rtl/divide_div_step.sv - one combinational restoring-division step
// rem_acc  in  partial remainder (WIDTH+1 bits)
// q_msb    in  next dividend bit shifted into the remainder
// div_reg  in  captured divisor
// rem_next out partial remainder after compare/subtract
// q_bit    out quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_acc,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] div_reg,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] t;

    always_comb begin
        t = {rem_acc[WIDTH-1:0], q_msb};
        // A set rem_acc MSB means the shifted value is beyond t's range and
        // therefore certainly >= the divisor; the subtraction still wraps to
        // the correct residue in WIDTH+1 bits.
        q_bit    = rem_acc[WIDTH] | (t >= {1'b0, div_reg});
        rem_next = q_bit ? (t - {1'b0, div_reg}) : t;
    end
endmodule

// File: rtl/divide.sv
// rtl/divide.sv - sequential restoring divider, one quotient bit per clock
// clock  in  rising-edge clock
// reset  in  synchronous active-high reset
// bus    slave side of divide_if: start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out
module divide
    import divide_pkg::*;
#(
    parameter int WIDTH = DIVIDE_WIDTH
) (
    input  logic     clock,
    input  logic     reset,
    divide_if.slave  bus
);
    localparam int QW = 2 * WIDTH;
    localparam int CW = $clog2(QW + 1);

    state_t           state, state_nxt;
    logic [WIDTH:0]   rem_acc;
    logic [QW-1:0]    q_acc;
    logic [WIDTH-1:0] div_reg;
    logic [CW-1:0]    count;

    logic             busy_r, done_r, dbz_r;
    logic [QW-1:0]    quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic             accept, zero_req, last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_acc  (rem_acc),
        .q_msb    (q_acc[QW-1]),
        .div_reg  (div_reg),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        zero_req  = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    // A zero divisor is answered directly from IDLE without iterating.
                    if (bus.divisor != '0) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        zero_req  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    last_step = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rem_acc     <= '0;
            q_acc       <= '0;
            div_reg     <= '0;
            count       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else begin
            state  <= state_nxt;
            done_r <= 1'b0;
            if (accept) begin
                rem_acc <= '0;
                q_acc   <= bus.dividend;
                div_reg <= bus.divisor;
                count   <= CW'(QW);
                busy_r  <= 1'b1;
            end
            if (zero_req) begin
                quotient_r  <= '1;
                remainder_r <= bus.dividend[WIDTH-1:0];
                dbz_r       <= 1'b1;
                done_r      <= 1'b1;
            end
            if (state == RUN) begin
                rem_acc <= rem_next;
                q_acc   <= {q_acc[QW-2:0], q_bit};
                count   <= count - 1'b1;
            end
            if (last_step) begin
                // Final remainder is below the divisor, so the low WIDTH bits hold it.
                quotient_r  <= {q_acc[QW-2:0], q_bit};
                remainder_r <= rem_next[WIDTH-1:0];
                dbz_r       <= 1'b0;
                done_r      <= 1'b1;
                busy_r      <= 1'b0;
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule
